// File: rtl/custom_gate_sweeper.sv
// custom_gate_sweeper
//   Stimulus/checker stage for a custom_gate cell (F = !C && (!A || B)).
//   On START it walks {A,B,C} through 000..111, holding each vector for
//   HOLD_CYCLES clocks. On the last hold cycle it samples F and compares it
//   with EXP_TABLE. It reports a per-vector mismatch mask, a mismatch count
//   and a pass flag. All outputs come straight from flops.
module custom_gate_sweeper #(
   parameter int         HOLD_CYCLES = 2,      // >= 1; F sampled on the last hold cycle
   parameter logic [7:0] EXP_TABLE   = 8'h45   // bit i = expected F for {A,B,C} == i
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic       F,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] FAIL_MASK,
   output logic [3:0] ERR_CNT
);

   // The hold counter only has to count 0..HOLD_CYCLES-1.
   localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      REPORT = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [2:0]    abc_q, abc_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [7:0]    fail_mask_q, fail_mask_d;
   logic [3:0]    err_cnt_q, err_cnt_d;
   logic          mismatch;

   // State register and all registered outputs.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         hold_q      <= '0;
         abc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         abc_q       <= abc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Next-state and next-output logic for the sweep sequencer.
   // NOTE: every signal gets a default before the case statement; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hold_d      = hold_q;
      abc_d       = abc_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;
      err_cnt_d   = err_cnt_q;
      mismatch    = (F != EXP_TABLE[idx_q]);

      unique case (state_q)
         IDLE: begin
            // START has priority over a simultaneous ABORT simply because
            // ABORT is not looked at here.
            if (START) begin
               state_d     = DRIVE;
               idx_d       = '0;
               hold_d      = '0;
               abc_d       = '0;
               busy_d      = 1'b1;
               pass_d      = 1'b0;
               fail_mask_d = '0;
               err_cnt_d   = '0;
            end
         end

         DRIVE: begin
            if (ABORT) begin
               // Drop the sample due on this edge and keep partial results.
               state_d = IDLE;
               busy_d  = 1'b0;
               abc_d   = '0;
               pass_d  = 1'b0;
            end else if (hold_q == HOLD_LAST) begin
               if (mismatch) begin
                  fail_mask_d[idx_q] = 1'b1;
                  err_cnt_d          = err_cnt_q + 4'd1;
               end
               if (idx_q == 3'd7) begin
                  // PASS includes the sample just taken on this edge.
                  state_d = REPORT;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  abc_d   = '0;
                  pass_d  = (err_cnt_d == 4'd0);
               end else begin
                  idx_d  = idx_q + 3'd1;
                  abc_d  = idx_q + 3'd1;
                  hold_d = '0;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         REPORT: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign A         = abc_q[2];
   assign B         = abc_q[1];
   assign C         = abc_q[0];
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign FAIL_MASK = fail_mask_q;
   assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_custom_gate_sweeper.sv
// Bench for custom_gate_sweeper: one instance with HOLD_CYCLES=2 and one with
// HOLD_CYCLES=1. F of each comes from a golden custom_gate model or a tie-off.
// Sweep results are queued when a sweep is launched and checked by a monitor
// whenever DONE pulses.
module tb_custom_gate_sweeper;

   typedef struct {
      logic       pass;
      logic [7:0] mask;
      logic [3:0] err;
      int         start_edge;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start2, abort2, f2, a2, b2, c2, busy2, done2, pass2;
   logic [7:0] mask2;
   logic [3:0] err2;
   logic       start1, abort1, f1, a1, b1, c1, busy1, done1, pass1;
   logic [7:0] mask1;
   logic [3:0] err1;

   int   fsel2 = 0;   // 0: golden gate, 1: F tied 0, 2: F tied 1
   int   fsel1 = 0;
   int   cyc = 0;     // number of rising edges so far
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt2 = 0;
   int   done_cnt1 = 0;
   int   e0;
   int   d_before;
   exp_t q2[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic golden(input logic a, input logic b, input logic c);
      return !c && (!a || b);
   endfunction

   assign f2 = (fsel2 == 0) ? golden(a2, b2, c2) : (fsel2 == 2);
   assign f1 = (fsel1 == 0) ? golden(a1, b1, c1) : (fsel1 == 2);

   custom_gate_sweeper #(.HOLD_CYCLES(2), .EXP_TABLE(8'h45)) u_dut2 (
      .CLK(clk), .RST_N(rst_n), .START(start2), .ABORT(abort2), .F(f2),
      .A(a2), .B(b2), .C(c2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
      .FAIL_MASK(mask2), .ERR_CNT(err2)
   );

   custom_gate_sweeper #(.HOLD_CYCLES(1), .EXP_TABLE(8'h45)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1), .F(f1),
      .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
      .FAIL_MASK(mask1), .ERR_CNT(err1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for the HOLD_CYCLES=2 instance.
   always @(negedge clk) begin : mon2
      exp_t e;
      if (done2 === 1'b1) begin
         done_cnt2 <= done_cnt2 + 1;
         check("dut2_done_expected", 32'(q2.size() != 0), 1);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            check("dut2_pass", pass2, e.pass);
            check("dut2_fail_mask", mask2, e.mask);
            check("dut2_err_cnt", err2, e.err);
            check("dut2_done_latency", cyc - e.start_edge, 16);
            check("dut2_busy_at_done", busy2, 0);
         end
      end
   end

   // Monitor for the HOLD_CYCLES=1 instance.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (done1 === 1'b1) begin
         done_cnt1 <= done_cnt1 + 1;
         check("dut1_done_expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("dut1_pass", pass1, e.pass);
            check("dut1_fail_mask", mask1, e.mask);
            check("dut1_err_cnt", err1, e.err);
            check("dut1_done_latency", cyc - e.start_edge, 8);
         end
      end
   end

   // Waits until the falling edge that follows rising edge number 'edge_n'.
   task automatic wait_to(input int edge_n);
      while (cyc < edge_n) @(negedge clk);
   endtask

   // Called at a falling edge; START is captured on the next rising edge.
   task automatic start_sweep2(input int fsel, input logic push, input logic ep,
                               input logic [7:0] em, input logic [3:0] ee, output int s_edge);
      exp_t e;
      fsel2  = fsel;
      start2 = 1'b1;
      s_edge = cyc + 1;
      if (push) begin
         e.pass = ep; e.mask = em; e.err = ee; e.start_edge = s_edge;
         q2.push_back(e);
      end
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic start_sweep1(input int fsel, input logic ep,
                               input logic [7:0] em, input logic [3:0] ee, output int s_edge);
      exp_t e;
      fsel1  = fsel;
      start1 = 1'b1;
      s_edge = cyc + 1;
      e.pass = ep; e.mask = em; e.err = ee; e.start_edge = s_edge;
      q1.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic wait_done2(input int budget);
      int target;
      int k;
      target = done_cnt2 + 1;
      k = 0;
      while (done_cnt2 < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("dut2_done_within_budget", 32'(done_cnt2 >= target), 1);
   endtask

   task automatic wait_done1(input int budget);
      int target;
      int k;
      target = done_cnt1 + 1;
      k = 0;
      while (done_cnt1 < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("dut1_done_within_budget", 32'(done_cnt1 >= target), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b1;
      start2 = 1'b0; abort2 = 1'b0;
      start1 = 1'b0; abort1 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      // Reset state.
      check("rst_abc", {a2, b2, c2}, 3'b000);
      check("rst_flags", {busy2, done2, pass2}, 3'b000);
      check("rst_fail_mask", mask2, 8'h00);
      check("rst_err_cnt", err2, 4'd0);
      check("rst_dut1_all", {a1, b1, c1, busy1, done1, pass1, mask1, err1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Golden gate, HOLD_CYCLES=2: vector k is presented from edge 2k.
      start_sweep2(0, 1'b1, 1'b1, 8'h00, 4'd0, e0);
      check("busy_in_drive", busy2, 1);
      for (int k = 0; k < 8; k++) begin
         wait_to(e0 + 2 * k + 1);
         check($sformatf("abc_vec%0d", k), {a2, b2, c2}, k[2:0]);
      end
      wait_done2(24);
      repeat (3) @(negedge clk);
      check("pass_held", pass2, 1);
      check("done_one_cycle", done2, 0);
      check("abc_idle", {a2, b2, c2}, 3'b000);

      // F tied 0.
      @(negedge clk);
      start_sweep2(1, 1'b1, 1'b0, 8'h45, 4'd3, e0);
      wait_done2(24);

      // F tied 1, with ABORT raised alongside START in IDLE (START wins).
      @(negedge clk);
      abort2 = 1'b1;
      start_sweep2(2, 1'b1, 1'b0, 8'hBA, 4'd5, e0);
      abort2 = 1'b0;
      check("start_beats_abort", busy2, 1);
      wait_done2(24);
      @(negedge clk);
      check("mask_held_after_done", mask2, 8'hBA);

      // ABORT on the vector-3 sample edge; START at IDX=1 must be ignored.
      @(negedge clk);
      start_sweep2(2, 1'b0, 1'b0, 8'h00, 4'd0, e0);
      wait_to(e0 + 2);
      start2 = 1'b1;
      wait_to(e0 + 3);
      start2 = 1'b0;
      wait_to(e0 + 5);
      check("start_ignored_in_drive", {a2, b2, c2}, 3'd2);
      wait_to(e0 + 7);
      abort2 = 1'b1;
      wait_to(e0 + 8);
      abort2 = 1'b0;
      check("abort_busy", busy2, 0);
      check("abort_abc", {a2, b2, c2}, 3'b000);
      check("abort_pass", pass2, 0);
      check("abort_partial_mask", mask2, 8'h02);
      check("abort_partial_err", err2, 4'd1);
      d_before = done_cnt2;
      repeat (20) @(negedge clk);
      #1;
      check("abort_no_done", done_cnt2, d_before);
      check("abort_stays_idle", busy2, 0);

      // Asynchronous reset in the middle of a sweep (IDX=5).
      @(negedge clk);
      start_sweep2(2, 1'b1, 1'b0, 8'hBA, 4'd5, e0);
      wait_to(e0 + 11);
      check("pre_reset_idx5", {a2, b2, c2}, 3'd5);
      check("pre_reset_mask", mask2, 8'h1A);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_abc", {a2, b2, c2}, 3'b000);
      check("async_rst_flags", {busy2, done2, pass2}, 3'b000);
      check("async_rst_mask", mask2, 8'h00);
      check("async_rst_err", err2, 4'd0);
      q2.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_sweep2(0, 1'b1, 1'b1, 8'h00, 4'd0, e0);
      wait_done2(24);

      // HOLD_CYCLES=1: a new vector on every edge.
      @(negedge clk);
      start_sweep1(0, 1'b1, 8'h00, 4'd0, e0);
      for (int k = 0; k < 8; k++) begin
         wait_to(e0 + k);
         check($sformatf("h1_abc_vec%0d", k), {a1, b1, c1}, k[2:0]);
      end
      wait_done1(12);
      // Back-to-back: START in the first IDLE cycle after DONE.
      @(negedge clk);
      start_sweep1(2, 1'b0, 8'hBA, 4'd5, e0);
      wait_done1(12);
      @(negedge clk);
      start_sweep1(0, 1'b1, 8'h00, 4'd0, e0);
      wait_done1(12);

      repeat (3) @(negedge clk);
      check("dut2_queue_drained", q2.size(), 0);
      check("dut1_queue_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
